// File: rtl/pc_ctrl.sv
// Program-counter control unit for the multicycle CPU. It holds the PC register, evaluates the
// eight branch conditions, and muxes the next-PC source. It also runs a two-cycle
// exception-entry sequence that saves the PC into an EPC register, and it keeps a saturating
// count of taken branches.
module pc_ctrl #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      RESET_PC   = '0,
  parameter logic [WIDTH-1:0]      EXC_VEC    = 32'h0000_00FC,
  parameter int unsigned           VEC_STRIDE = 4,
  parameter int unsigned           CAUSE_W    = 2,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write,
  input  logic               pc_write_cond,
  input  logic [2:0]         cond_sel,
  input  logic               zero,
  input  logic               gt,
  input  logic [1:0]         pc_src,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [WIDTH-1:0]   jump_target,
  input  logic               stall,
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               exc_busy,
  output logic               branch_taken,
  output logic [CNT_W-1:0]   taken_cnt
);

  typedef enum logic [1:0] {StRun, StExcSave, StExcJump} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, epc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cond_true;
  logic               pc_en;
  logic               in_run;
  logic [WIDTH-1:0]   src_pc;
  logic [WIDTH-1:0]   vec_pc;

  // Branch condition decode from the ALU flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond_sel)
      3'b000:  cond_true = zero;
      3'b001:  cond_true = ~zero;
      3'b010:  cond_true = gt;
      3'b011:  cond_true = ~gt;
      3'b100:  cond_true = ~gt & ~zero;
      3'b101:  cond_true = gt | zero;
      3'b110:  cond_true = 1'b1;
      3'b111:  cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-PC source mux and per-cause exception vector (wraps modulo 2^WIDTH).
  always_comb begin
    src_pc = alu_result;
    unique case (pc_src)
      2'b00:   src_pc = alu_result;
      2'b01:   src_pc = alu_out;
      2'b10:   src_pc = jump_target;
      2'b11:   src_pc = epc_q;
      default: src_pc = alu_result;
    endcase
    vec_pc = EXC_VEC + (WIDTH'(cause_q) * WIDTH'(VEC_STRIDE));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: an exception request is only accepted from RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (exc_req) state_d = StExcSave;
      StExcSave: state_d = StExcJump;
      StExcJump: state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  // FSM outputs: PC enable and branch-taken are only live in RUN.
  always_comb begin
    in_run       = (state_q == StRun);
    exc_busy     = ~in_run;
    pc_en        = in_run & ~stall & ~exc_req & (pc_write | (pc_write_cond & cond_true));
    branch_taken = pc_write_cond & cond_true & pc_en;
  end

  // PC, EPC and cause registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (exc_req) begin
            epc_q   <= pc_q;
            cause_q <= exc_cause;
          end else if (pc_en) begin
            pc_q <= src_pc;
          end
        end
        StExcJump: pc_q <= vec_pc;
        default:   pc_q <= pc_q;
      endcase
    end
  end

  // Saturating taken-branch counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (branch_taken && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign taken_cnt = cnt_q;

endmodule
